// File: rtl/ysyx_210184_lsu_stage.sv
// ysyx_210184_lsu_stage: memory stage between EX and WB; one load/store at a time on a valid/ready bus
// Ports: clk/rst (async, active-high); ex_* instruction from EX (held while stall);
// dmem_req_*/dmem_rsp_* data bus; stall/flush/redirect_pc pipeline control;
// wb_* registered write-back payload; exc_* registered misaligned-access exception.
// Optional: YSYX_210184_MISALIGN_EXC_EN raises exceptions on misaligned accesses
// instead of forcing natural alignment.
module ysyx_210184_lsu_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [RD_W-1:0]      ex_rd,
  input  logic                 ex_wen,
  input  logic                 ex_load,
  input  logic                 ex_store,
  input  logic [1:0]           ex_size,
  input  logic                 ex_unsigned,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic                 ex_csr,
  input  logic [XLEN-1:0]      ex_csr_rdata,
  input  logic                 ex_jump,
  input  logic                 ex_trap,
  input  logic                 ex_mret,
  input  logic                 intr_pending,
  input  logic [XLEN-1:0]      csr_mtvec,
  input  logic [XLEN-1:0]      csr_mepc,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_wen,
  output logic [XLEN-1:0]      dmem_req_addr,
  output logic [1:0]           dmem_req_size,
  output logic [XLEN-1:0]      dmem_req_wdata,
  output logic [XLEN/8-1:0]    dmem_req_wstrb,
  input  logic                 dmem_rsp_valid,
  input  logic [XLEN-1:0]      dmem_rsp_rdata,
  output logic                 stall,
  output logic                 flush,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 wb_valid,
  output logic                 wb_wen,
  output logic [RD_W-1:0]      wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 exc_valid,
  output logic [3:0]           exc_cause,
  output logic [XLEN-1:0]      exc_tval
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam logic [1:0] SZ_MAX = 2'(LB);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [1:0] r_size;
  logic r_wen;
  logic [NB-1:0] r_wstrb, w_bmask;
  logic w_idle, w_mem, w_mis, w_go, w_alu, w_done, w_sign;
  logic [2:0] w_lo;
  logic [XLEN-1:0] w_addr, w_sh, w_mask, w_ld, w_res;
  assign w_idle = r_state == IDLE;
  assign w_mem  = ex_valid & (ex_load | ex_store);
  assign w_lo   = 3'((4'd1 << ex_size) - 4'd1);
`ifdef YSYX_210184_MISALIGN_EXC_EN
  assign w_mis  = w_mem & |(ex_result[2:0] & w_lo);
  assign w_addr = ex_result;
`else
  assign w_mis  = 1'b0;
  assign w_addr = {ex_result[XLEN-1:3], ex_result[2:0] & ~w_lo};
`endif
  // an interrupt kills the presented instruction, so nothing issues or retires with it
  assign w_go   = w_idle & w_mem & ~w_mis & ~intr_pending;
  assign w_alu  = w_idle & ex_valid & ~(ex_load | ex_store) & ~intr_pending;
  assign w_done = ((r_state == REQ & dmem_req_ready) | r_state == WAIT) & dmem_rsp_valid;
  assign w_bmask = ex_size >= SZ_MAX ? '1 : (NB'(1) << (4'd1 << ex_size)) - NB'(1);
  assign w_sh   = dmem_rsp_rdata >> {r_addr[LB-1:0], 3'b000};
  assign w_mask = r_size >= SZ_MAX ? '1 : (XLEN'(1) << (7'd8 << r_size)) - XLEN'(1);
  // top bit of the access-sized field is the sign bit
  assign w_sign = |(w_sh & w_mask & ~(w_mask >> 1));
  assign w_ld   = (w_sh & w_mask) | ((~ex_unsigned & w_sign) ? ~w_mask : '0);
  assign w_res  = ex_load ? w_ld : ex_csr ? ex_csr_rdata : ex_result;
  assign dmem_req_valid = r_state == REQ;
  assign dmem_req_wen   = r_wen;
  assign dmem_req_addr  = r_addr;
  assign dmem_req_size  = r_size;
  assign dmem_req_wdata = r_wdata;
  assign dmem_req_wstrb = r_wstrb;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = w_go ? REQ :
             (r_state == REQ & dmem_req_ready) ? (dmem_rsp_valid ? IDLE : WAIT) :
             (r_state == WAIT & dmem_rsp_valid) ? IDLE : r_state;
    stall = w_go | r_state == REQ | (r_state == WAIT & ~dmem_rsp_valid);
    flush = w_idle & ex_valid & (intr_pending | w_mis | ex_trap | ex_mret | ex_jump);
    redirect_pc = (intr_pending | w_mis | ex_trap) ? csr_mtvec : ex_mret ? csr_mepc : ex_result;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_wen    <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      if (w_go) begin
        r_addr  <= w_addr;
        r_size  <= ex_size;
        r_wen   <= ex_store;
        r_wdata <= ex_wdata << {w_addr[LB-1:0], 3'b000};
        r_wstrb <= w_bmask << w_addr[LB-1:0];
      end
      wb_valid <= w_alu | w_done;
      if (w_alu | w_done) begin
        wb_wen  <= ex_wen & ~ex_store;
        wb_rd   <= ex_rd;
        wb_data <= w_res;
      end
    end
`ifdef YSYX_210184_MISALIGN_EXC_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_tval  <= '0;
    end else begin
      exc_valid <= w_idle & w_mis & ~intr_pending;
      if (w_idle & w_mis & ~intr_pending) begin
        exc_cause <= ex_store ? 4'd6 : 4'd4;
        exc_tval  <= ex_result;
      end
    end
`else
  assign exc_valid = 1'b0;
  assign exc_cause = '0;
  assign exc_tval  = '0;
`endif
endmodule

// File: tb/tb_ysyx_210184_lsu_stage.sv
// tb_ysyx_210184_lsu_stage: table-driven and directed checks of the LSU stage
module tb_ysyx_210184_lsu_stage;
  localparam logic [63:0] MTVEC = 64'h8000_0100;
  localparam logic [63:0] MEPC  = 64'h8000_0200;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid, ex_wen, ex_load, ex_store, ex_unsigned, ex_csr, ex_jump, ex_trap, ex_mret, intr_pending;
  logic [63:0] ex_result, ex_wdata, ex_csr_rdata, csr_mtvec, csr_mepc;
  logic [4:0] ex_rd;
  logic [1:0] ex_size;
  logic dmem_req_valid, dmem_req_ready, dmem_req_wen, dmem_rsp_valid;
  logic [63:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata;
  logic [1:0] dmem_req_size;
  logic [7:0] dmem_req_wstrb;
  logic stall, flush, wb_valid, wb_wen, exc_valid;
  logic [63:0] redirect_pc, wb_data, exc_tval;
  logic [4:0] wb_rd;
  logic [3:0] exc_cause;
  int n_chk = 0, n_fail = 0;

  ysyx_210184_lsu_stage #(.XLEN(64), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_wdata(ex_wdata), .ex_csr(ex_csr), .ex_csr_rdata(ex_csr_rdata),
    .ex_jump(ex_jump), .ex_trap(ex_trap), .ex_mret(ex_mret), .intr_pending(intr_pending),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_req_wen(dmem_req_wen), .dmem_req_addr(dmem_req_addr),
    .dmem_req_size(dmem_req_size), .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld; logic st; logic [1:0] sz; logic uns;
    logic [63:0] addr; logic [63:0] wdata; logic [63:0] rdata;
    logic [63:0] e_wdata; logic [63:0] e_wb; logic [7:0] e_strb;
  } mem_vec_t;
  typedef struct {
    logic [63:0] res; logic csr; logic [63:0] csrd; logic jmp; logic trp; logic mrt;
    logic e_fl; logic [63:0] e_pc; logic [63:0] e_wb;
  } alu_vec_t;
  mem_vec_t mv[11];
  alu_vec_t av[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_wen = 0; ex_load = 0; ex_store = 0; ex_unsigned = 0; ex_csr = 0;
    ex_jump = 0; ex_trap = 0; ex_mret = 0; intr_pending = 0; ex_size = 0; ex_rd = 0;
    ex_result = 0; ex_wdata = 0; ex_csr_rdata = 0;
  endtask

  task automatic drive_mem(input mem_vec_t v, input logic [4:0] rd);
    clear_ex();
    ex_valid = 1; ex_wen = 1; ex_load = v.ld; ex_store = v.st; ex_size = v.sz;
    ex_unsigned = v.uns; ex_result = v.addr; ex_wdata = v.wdata; ex_rd = rd;
  endtask

  int scnt;

  initial begin
    clear_ex();
    csr_mtvec = MTVEC; csr_mepc = MEPC;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
    mv[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 8'h08};
    mv[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 64'h0000_0000_0000_0080, 8'h08};
    mv[2]  = '{1'b1, 1'b0, 2'd1, 1'b0, 64'h1006, 64'h0, 64'h8765_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_8765, 8'hC0};
    mv[3]  = '{1'b1, 1'b0, 2'd2, 1'b1, 64'h1004, 64'h0, 64'hDEAD_BEEF_1234_5678, 64'h0, 64'h0000_0000_DEAD_BEEF, 8'hF0};
    mv[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h1000, 64'h0, 64'hDEAD_BEEF_9234_5678, 64'h0, 64'hFFFF_FFFF_9234_5678, 8'h0F};
    mv[5]  = '{1'b1, 1'b0, 2'd3, 1'b0, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF};
    mv[6]  = '{1'b1, 1'b0, 2'd1, 1'b1, 64'h1002, 64'h0, 64'h0000_0000_F00D_0000, 64'h0, 64'h0000_0000_0000_F00D, 8'h0C};
    mv[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 64'h3006, 64'hABCD, 64'h0, 64'hABCD_0000_0000_0000, 64'h3006, 8'hC0};
    mv[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 64'h3001, 64'h1122_3344_5566_77AA, 64'h0, 64'h2233_4455_6677_AA00, 64'h3001, 8'h02};
    mv[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 64'h3004, 64'hCAFE_F00D, 64'h0, 64'hCAFE_F00D_0000_0000, 64'h3004, 8'hF0};
    mv[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 64'h3008, 64'h1122_3344_5566_7788, 64'h0, 64'h1122_3344_5566_7788, 64'h3008, 8'hFF};
    av[0] = '{64'h1234, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h1234};
    av[1] = '{64'h99, 1'b1, 64'h55AA, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h55AA};
    av[2] = '{64'h8000_0040, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0040, 64'h8000_0040};
    av[3] = '{64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, MTVEC, 64'h0};
    av[4] = '{64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, MEPC, 64'h0};
    av[5] = '{64'h8000_0040, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, MTVEC, 64'h8000_0040};
    av[6] = '{64'h8000_0044, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, MEPC, 64'h8000_0044};

    @(negedge clk); #1;
    chk("rst req_valid", dmem_req_valid, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst stall", stall, 0);
    chk("rst exc_valid", exc_valid, 0);
    chk("rst req_addr", dmem_req_addr, 0);
    @(negedge clk); rst = 0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("mem%0d wb_valid idle", i), wb_valid, 0);
      drive_mem(mv[i], 5'(i + 1));
      #1;
      chk($sformatf("mem%0d issue stall", i), stall, 1);
      chk($sformatf("mem%0d issue req_valid", i), dmem_req_valid, 0);
      @(negedge clk); #1;
      chk($sformatf("mem%0d req_valid", i), dmem_req_valid, 1);
      chk($sformatf("mem%0d req_addr", i), dmem_req_addr, mv[i].addr);
      chk($sformatf("mem%0d req_wstrb", i), dmem_req_wstrb, mv[i].e_strb);
      chk($sformatf("mem%0d req_wen", i), dmem_req_wen, mv[i].st);
      chk($sformatf("mem%0d req_size", i), dmem_req_size, mv[i].sz);
      if (mv[i].st) chk($sformatf("mem%0d req_wdata", i), dmem_req_wdata, mv[i].e_wdata);
      dmem_req_ready = 1;
      @(negedge clk);
      dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = mv[i].rdata;
      #1;
      chk($sformatf("mem%0d rsp stall", i), stall, 0);
      @(negedge clk);
      clear_ex(); dmem_rsp_valid = 0;
      #1;
      chk($sformatf("mem%0d wb_valid", i), wb_valid, 1);
      chk($sformatf("mem%0d wb_data", i), wb_data, mv[i].e_wb);
      chk($sformatf("mem%0d wb_wen", i), wb_wen, mv[i].ld);
      chk($sformatf("mem%0d wb_rd", i), wb_rd, 64'(i + 1));
    end

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("alu%0d wb_valid idle", i), wb_valid, 0);
      clear_ex();
      ex_valid = 1; ex_wen = 1; ex_rd = 5'(i + 20); ex_result = av[i].res; ex_csr = av[i].csr;
      ex_csr_rdata = av[i].csrd; ex_jump = av[i].jmp; ex_trap = av[i].trp; ex_mret = av[i].mrt;
      #1;
      chk($sformatf("alu%0d stall", i), stall, 0);
      chk($sformatf("alu%0d flush", i), flush, av[i].e_fl);
      if (av[i].e_fl) chk($sformatf("alu%0d redirect", i), redirect_pc, av[i].e_pc);
      @(negedge clk);
      clear_ex();
      #1;
      chk($sformatf("alu%0d wb_valid", i), wb_valid, 1);
      chk($sformatf("alu%0d wb_data", i), wb_data, av[i].e_wb);
      chk($sformatf("alu%0d wb_rd", i), wb_rd, 64'(i + 20));
      chk($sformatf("alu%0d wb_wen", i), wb_wen, 1);
    end

    // stall length for a load with ready at once and response one cycle later
    scnt = 0;
    @(negedge clk); drive_mem(mv[0], 5'd3); #1; if (stall) scnt++;
    @(negedge clk); dmem_req_ready = 1; #1; if (stall) scnt++;
    @(negedge clk); dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = mv[0].rdata; #1; if (stall) scnt++;
    @(negedge clk); clear_ex(); dmem_rsp_valid = 0; #1; if (stall) scnt++;
    chk("lb stall cycles", 64'(scnt), 2);
    chk("lb wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);

    // ready held low; a stray response during REQ is ignored; ready+rsp together completes
    @(negedge clk); drive_mem(mv[9], 5'd7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dmem_rsp_valid = (k == 1 || k == 3); dmem_req_ready = (k == 3);
      #1;
      chk($sformatf("hold%0d req_valid", k), dmem_req_valid, 1);
      chk($sformatf("hold%0d req_addr", k), dmem_req_addr, 64'h3004);
      chk($sformatf("hold%0d req_wstrb", k), dmem_req_wstrb, 8'hF0);
      chk($sformatf("hold%0d req_wdata", k), dmem_req_wdata, 64'hCAFE_F00D_0000_0000);
      chk($sformatf("hold%0d stall", k), stall, 1);
      chk($sformatf("hold%0d wb_valid", k), wb_valid, 0);
    end
    @(negedge clk); clear_ex(); dmem_req_ready = 0; dmem_rsp_valid = 0; #1;
    chk("hold done req_valid", dmem_req_valid, 0);
    chk("hold done wb_valid", wb_valid, 1);
    chk("hold done wb_wen", wb_wen, 0);

    // interrupt kills an ALU op and a load presented in IDLE
    @(negedge clk); clear_ex(); ex_valid = 1; ex_wen = 1; ex_result = 64'h1234; intr_pending = 1; #1;
    chk("intr alu flush", flush, 1);
    chk("intr alu redirect", redirect_pc, MTVEC);
    @(negedge clk); clear_ex(); #1;
    chk("intr alu wb_valid", wb_valid, 0);
    @(negedge clk); drive_mem(mv[0], 5'd4); intr_pending = 1; #1;
    chk("intr ld flush", flush, 1);
    @(negedge clk); clear_ex(); #1;
    chk("intr ld req_valid", dmem_req_valid, 0);
    chk("intr ld wb_valid", wb_valid, 0);

    // interrupt during WAIT: load finishes, then the next instruction is flushed
    @(negedge clk); drive_mem(mv[5], 5'd5);
    @(negedge clk); dmem_req_ready = 1;
    @(negedge clk); dmem_req_ready = 0; intr_pending = 1; #1;
    chk("intr wait flush", flush, 0);
    chk("intr wait stall", stall, 1);
    @(negedge clk); dmem_rsp_valid = 1; dmem_rsp_rdata = mv[5].rdata; #1;
    chk("intr rsp flush", flush, 0);
    chk("intr rsp stall", stall, 0);
    @(negedge clk); dmem_rsp_valid = 0; clear_ex(); ex_valid = 1; ex_result = 64'h42; intr_pending = 1; #1;
    chk("intr after wb_valid", wb_valid, 1);
    chk("intr after wb_data", wb_data, 64'h0123_4567_89AB_CDEF);
    chk("intr after flush", flush, 1);
    chk("intr after redirect", redirect_pc, MTVEC);
    @(negedge clk); clear_ex(); #1;
    chk("intr after wb_valid clr", wb_valid, 0);

    // reset during WAIT, then a late response
    @(negedge clk); drive_mem(mv[4], 5'd6);
    @(negedge clk); dmem_req_ready = 1;
    @(negedge clk); dmem_req_ready = 0; #1;
    chk("rstw stall before", stall, 1);
    #1; rst = 1; clear_ex(); #1;
    chk("rstw req_valid", dmem_req_valid, 0);
    chk("rstw req_addr", dmem_req_addr, 0);
    chk("rstw req_wstrb", dmem_req_wstrb, 0);
    chk("rstw stall", stall, 0);
    chk("rstw wb_valid", wb_valid, 0);
    chk("rstw wb_data", wb_data, 0);
    @(negedge clk); rst = 0;
    @(negedge clk); dmem_rsp_valid = 1; dmem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); dmem_rsp_valid = 0; #1;
    chk("rstw late wb_valid", wb_valid, 0);
    chk("rstw late req_valid", dmem_req_valid, 0);
    @(negedge clk); #1;
    chk("rstw late2 wb_valid", wb_valid, 0);

`ifdef YSYX_210184_MISALIGN_EXC_EN
    @(negedge clk); clear_ex(); ex_valid = 1; ex_wen = 1; ex_load = 1; ex_size = 2; ex_result = 64'h1002; #1;
    chk("mis ld flush", flush, 1);
    chk("mis ld redirect", redirect_pc, MTVEC);
    chk("mis ld stall", stall, 0);
    @(negedge clk); clear_ex(); #1;
    chk("mis ld req_valid", dmem_req_valid, 0);
    chk("mis ld exc_valid", exc_valid, 1);
    chk("mis ld exc_cause", exc_cause, 4);
    chk("mis ld exc_tval", exc_tval, 64'h1002);
    chk("mis ld wb_valid", wb_valid, 0);
    @(negedge clk); clear_ex(); ex_valid = 1; ex_store = 1; ex_size = 1; ex_result = 64'h3001; #1;
    chk("mis st flush", flush, 1);
    @(negedge clk); clear_ex(); #1;
    chk("mis st req_valid", dmem_req_valid, 0);
    chk("mis st exc_valid", exc_valid, 1);
    chk("mis st exc_cause", exc_cause, 6);
    chk("mis st exc_tval", exc_tval, 64'h3001);
    @(negedge clk); #1;
    chk("mis exc_valid clr", exc_valid, 0);
`else
    @(negedge clk); clear_ex(); ex_valid = 1; ex_wen = 1; ex_load = 1; ex_size = 2; ex_unsigned = 1;
    ex_rd = 5'd9; ex_result = 64'h1002; #1;
    chk("align flush", flush, 0);
    chk("align stall", stall, 1);
    @(negedge clk); #1;
    chk("align req_addr", dmem_req_addr, 64'h1000);
    chk("align req_wstrb", dmem_req_wstrb, 8'h0F);
    dmem_req_ready = 1;
    @(negedge clk); dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h0000_0000_CAFE_BABE;
    @(negedge clk); clear_ex(); dmem_rsp_valid = 0; #1;
    chk("align wb_data", wb_data, 64'h0000_0000_CAFE_BABE);
    chk("align exc_valid", exc_valid, 0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
